// File: rtl/gf256_inverse_serial_if.sv
// Handshake bundle for the serial GF(2^8) inverter: an input byte channel
// and an output byte channel, each with its own valid/ready pair.
interface gf256_inverse_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] byte_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] byte_out;

    // Producer of input bytes and consumer of results
    modport master (
        output in_valid,
        input  in_ready,
        output byte_in,
        input  out_valid,
        output out_ready,
        input  byte_out
    );

    // The inverter itself
    modport slave (
        input  in_valid,
        output in_ready,
        input  byte_in,
        output out_valid,
        input  out_ready,
        output byte_out
    );
endinterface

// File: rtl/gf256_inverse_serial.sv
// Iterative GF(2^8) multiplicative inverse, x^254, using one bit-serial
// multiplier. r accumulates x^2 * x^4 * ... * x^128 over seven multiplies
// of eight Horner steps each; s walks the successive squares. x = 0 needs
// no special handling since the first product is already zero.
module gf256_inverse_serial #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic                        clk,
    input  logic                        rst,
    gf256_inverse_serial_if.slave       bus
);

    // Full 9-bit reduction polynomial, widened for the squaring fold
    localparam logic [14:0] RED = {6'd0, 1'b1, POLY};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] r_reg, r_next;
    logic [7:0] s_reg, s_next;
    logic [7:0] acc_reg, acc_next;
    logic [2:0] k_reg, k_next;
    logic [2:0] iter_reg, iter_next;
    logic [7:0] out_reg, out_next;

    logic [7:0] sq_in;
    logic [7:0] sq_s;
    logic [7:0] acc_shift;
    logic [7:0] partial;
    logic [7:0] horner_step;
    logic       s_bit;

    // Squaring is linear over GF(2): spread bit i to position 2i, then fold
    // the high terms back down with the reduction polynomial.
    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[2*i] = a[i];
        end
        for (int j = 14; j >= 8; j--) begin
            if (p[j]) begin
                p = p ^ (RED << (j - 8));
            end
        end
        return p[7:0];
    endfunction

    assign sq_in = gf_sq(bus.byte_in);
    assign sq_s  = gf_sq(s_reg);

    // MSB-first Horner: multiply the accumulator by x, then add r if the
    // current bit of s is set.
    assign s_bit     = s_reg[3'd7 - k_reg];
    assign acc_shift = {acc_reg[6:0], 1'b0} ^ (acc_reg[7] ? POLY : 8'h00);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_partial
            assign partial[gi] = s_bit & r_reg[gi];
        end
    endgenerate

    assign horner_step = acc_shift ^ partial;

    // State and datapath registers; reset discards any in-flight byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            r_reg     <= 8'h00;
            s_reg     <= 8'h00;
            acc_reg   <= 8'h00;
            k_reg     <= 3'd0;
            iter_reg  <= 3'd0;
            out_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            s_reg     <= s_next;
            acc_reg   <= acc_next;
            k_reg     <= k_next;
            iter_reg  <= iter_next;
            out_reg   <= out_next;
        end
    end

    // Next-state and datapath update: accept, step the multiplier, hand off
    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        s_next     = s_reg;
        acc_next   = acc_reg;
        k_next     = k_reg;
        iter_next  = iter_reg;
        out_next   = out_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    s_next     = sq_in;
                    r_next     = 8'h01;
                    acc_next   = 8'h00;
                    k_next     = 3'd0;
                    iter_next  = 3'd0;
                    state_next = MULT;
                end
            end
            MULT: begin
                acc_next = horner_step;
                k_next   = k_reg + 3'd1;
                if (k_reg == 3'd7) begin
                    // Product complete: fold into r and move to next square
                    r_next   = horner_step;
                    s_next   = sq_s;
                    acc_next = 8'h00;
                    k_next   = 3'd0;
                    if (iter_reg == 3'd6) begin
                        out_next   = horner_step;
                        state_next = DONE;
                    end else begin
                        iter_next = iter_reg + 3'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.byte_out  = out_reg;

endmodule

// File: tb/tb_gf256_inverse_serial.sv
// Directed bench for the serial GF(2^8) inverter: known vectors, back-to-back
// timing, exhaustive sweep against a reference, backpressure, mid-run reset
// and input changes after acceptance.
module tb_gf256_inverse_serial;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    gf256_inverse_serial_if bus ();

    gf256_inverse_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [6];

    // Reference multiply, LSB-first shift-and-add
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference inverse by brute-force search
    function automatic logic [7:0] ref_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (ref_mul(a, 8'(y)) == 8'h01) r = 8'(y);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called near a negedge while IDLE: present a byte, take it at the next edge
    task automatic accept(input logic [7:0] v);
        check("accept_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.byte_in  = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    endtask

    // Count negedges after the accept edge until out_valid, bounded
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 200);
        if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    // Full transaction with out_ready held high; returns at the first IDLE negedge
    task automatic run_one(input logic [7:0] v, output logic [7:0] res, output int lat);
        accept(v);
        wait_out(lat);
        res = bus.byte_out;
        @(negedge clk);
        check("idle_after_xfer", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] res;
        int         lat;
        int         t_acc [3];
        logic [7:0] b2b_in  [3];
        logic [7:0] b2b_exp [3];
        int         stray;

        checks = 0;
        errors = 0;
        cyc    = 0;

        vecs[0] = '{x: 8'h53, y: 8'hCA};
        vecs[1] = '{x: 8'h01, y: 8'h01};
        vecs[2] = '{x: 8'h02, y: 8'h8D};
        vecs[3] = '{x: 8'h00, y: 8'h00};
        vecs[4] = '{x: 8'hFF, y: 8'h1C};
        vecs[5] = '{x: 8'h03, y: 8'hF6};

        b2b_in[0] = 8'h01; b2b_exp[0] = 8'h01;
        b2b_in[1] = 8'h02; b2b_exp[1] = 8'h8D;
        b2b_in[2] = 8'h00; b2b_exp[2] = 8'h00;

        bus.in_valid  = 1'b0;
        bus.byte_in   = 8'h00;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_byte_out", 32'(bus.byte_out), 32'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Known vectors with exact latency
        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i].x, res, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd57);
            check($sformatf("vec%0d_result_x%02h", i, vecs[i].x), 32'(res), 32'(vecs[i].y));
            $display("vector x=%02h -> %02h (latency %0d)", vecs[i].x, res, lat);
        end

        // Back-to-back, out_ready tied high: accepts 58 cycles apart
        for (int i = 0; i < 3; i++) begin
            accept(b2b_in[i]);
            t_acc[i] = cyc;
            wait_out(lat);
            check($sformatf("b2b%0d_latency", i), 32'(lat), 32'd57);
            check($sformatf("b2b%0d_result", i), 32'(bus.byte_out), 32'(b2b_exp[i]));
            $display("back-to-back x=%02h -> %02h at cycle %0d", b2b_in[i], bus.byte_out, t_acc[i]);
            @(negedge clk);
            check($sformatf("b2b%0d_idle", i), 32'(bus.in_ready), 32'd1);
        end
        check("b2b_spacing_01", 32'(t_acc[1] - t_acc[0]), 32'd58);
        check("b2b_spacing_12", 32'(t_acc[2] - t_acc[1]), 32'd58);

        // Exhaustive sweep against the reference model
        for (int x = 0; x < 256; x++) begin
            run_one(8'(x), res, lat);
            check($sformatf("sweep_%02h", x), 32'(res), 32'(ref_inv(8'(x))));
            if (x != 0) check($sformatf("sweep_prod_%02h", x), 32'(ref_mul(8'(x), res)), 32'h01);
            $display("sweep x=%02h -> %02h", x, res);
        end

        // Backpressure: DONE holds, in_valid ignored during stall and at transfer
        bus.out_ready = 1'b0;
        accept(8'h53);
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd57);
        bus.in_valid = 1'b1;
        bus.byte_in  = 8'h02;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_byte_out", i), 32'(bus.byte_out), 32'hCA);
            check($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_xfer_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_xfer_in_ready", 32'(bus.in_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) stray++;
        end
        check("bp_not_consumed", 32'(stray), 32'd0);
        $display("backpressure x=53 held %02h, stray activity %0d", bus.byte_out, stray);

        // Reset mid-operation at cycle 20
        @(negedge clk);
        accept(8'h53);
        repeat (19) @(posedge clk);
        #1;
        check("mid_byte_out_pre", 32'(bus.byte_out), 32'hCA);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_byte_out", 32'(bus.byte_out), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        accept(8'h02);
        wait_out(lat);
        check("mid_post_latency", 32'(lat), 32'd57);
        check("mid_post_result", 32'(bus.byte_out), 32'h8D);
        $display("reset mid-run, then x=02 -> %02h (latency %0d)", bus.byte_out, lat);
        @(negedge clk);

        // byte_in changes after acceptance are ignored
        accept(8'h02);
        bus.byte_in = 8'hFF;
        wait_out(lat);
        check("chg_latency", 32'(lat), 32'd57);
        check("chg_result", 32'(bus.byte_out), 32'h8D);
        $display("input changed after accept: x=02 -> %02h", bus.byte_out);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
